// File: rtl/img_descpt_feeder.sv
// Image descriptor feeder: serves matcher requests with 4-descriptor groups read from the
// single-port descriptor memory, and lends that memory to the writer whenever no fetch is in flight.
module img_descpt_feeder #(
    parameter int DW = 403,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [10:0]   kpt_num,
    input  logic          descriptor_request,
    output logic          descriptor_valid,
    output logic [DW-1:0] image_R_C_D_0,
    output logic [DW-1:0] image_R_C_D_1,
    output logic [DW-1:0] image_R_C_D_2,
    output logic [DW-1:0] image_R_C_D_3,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_dout,
    input  logic          wr_req,
    output logic          wr_gnt,
    output logic [8:0]    grp_idx,
    output logic          all_fed
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REQ,
        FETCH,
        VALID
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [8:0]    grp_idx_q, grp_idx_d;
    logic [8:0]    grp_num_q, grp_num_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_re_q, mem_re_d;
    logic          valid_q, valid_d;
    logic          all_fed_q, all_fed_d;
    logic [DW-1:0] slot_q [4];
    logic [DW-1:0] slot_d [4];

    // A trailing partial group is dropped, so the two low keypoint bits never matter.
    logic unused_kpt_lsb;
    assign unused_kpt_lsb = ^kpt_num[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grp_idx_d = grp_idx_q;
        grp_num_d = grp_num_q;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end

        case (state_q)
            IDLE: ;
            WAIT_REQ: begin
                if (descriptor_request && !wr_req && (grp_idx_q < grp_num_q)) begin
                    state_d = FETCH;
                    cnt_d   = 3'd0;
                end
            end
            FETCH: begin
                if (cnt_q == 3'd4) begin
                    state_d = VALID;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            VALID: begin
                grp_idx_d = grp_idx_q + 9'd1;
                state_d   = WAIT_REQ;
            end
            default: state_d = IDLE;
        endcase

        // Read data trails the address by one cycle, so count c lands in slot c-1.
        for (int i = 0; i < 4; i++) begin
            if ((state_q == FETCH) && !start && (cnt_q == 3'(i + 1))) begin
                slot_d[i] = mem_dout;
            end
        end

        if (start) begin
            state_d   = WAIT_REQ;
            cnt_d     = 3'd0;
            grp_idx_d = 9'd0;
            grp_num_d = kpt_num[10:2];
        end

        // Outputs are registered from next-state values so they line up with the state.
        mem_re_d   = (state_d == FETCH) && (cnt_d < 3'd4);
        mem_addr_d = mem_re_d ? AW'({grp_idx_d, cnt_d[1:0]}) : mem_addr_q;
        valid_d    = (state_d == VALID);
        all_fed_d  = (state_d != IDLE) && (grp_idx_d == grp_num_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            grp_idx_q  <= 9'd0;
            grp_num_q  <= 9'd0;
            mem_addr_q <= '0;
            mem_re_q   <= 1'b0;
            valid_q    <= 1'b0;
            all_fed_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grp_idx_q  <= grp_idx_d;
            grp_num_q  <= grp_num_d;
            mem_addr_q <= mem_addr_d;
            mem_re_q   <= mem_re_d;
            valid_q    <= valid_d;
            all_fed_q  <= all_fed_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // The writer may only take the port while no fetch can be driving it.
    assign wr_gnt = wr_req && ((state_q == IDLE) || (state_q == WAIT_REQ));

    assign descriptor_valid = valid_q;
    assign mem_re           = mem_re_q;
    assign mem_addr         = mem_addr_q;
    assign grp_idx          = grp_idx_q;
    assign all_fed          = all_fed_q;
    assign image_R_C_D_0    = slot_q[0];
    assign image_R_C_D_1    = slot_q[1];
    assign image_R_C_D_2    = slot_q[2];
    assign image_R_C_D_3    = slot_q[3];

endmodule

// File: tb/tb_img_descpt_feeder.sv
// Scoreboard bench for img_descpt_feeder: memory word k holds k; expected groups are queued
// when a request is issued and compared when descriptor_valid pulses.
module tb_img_descpt_feeder;

    localparam int DW = 403;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [10:0]   kpt_num;
    logic          descriptor_request;
    logic          descriptor_valid;
    logic [DW-1:0] image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_dout = '0;
    logic          wr_req;
    logic          wr_gnt;
    logic [8:0]    grp_idx;
    logic          all_fed;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int mon_base;
    int sb[$];
    int addr_log[$];

    img_descpt_feeder #(.DW(DW), .AW(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .kpt_num           (kpt_num),
        .descriptor_request(descriptor_request),
        .descriptor_valid  (descriptor_valid),
        .image_R_C_D_0     (image_R_C_D_0),
        .image_R_C_D_1     (image_R_C_D_1),
        .image_R_C_D_2     (image_R_C_D_2),
        .image_R_C_D_3     (image_R_C_D_3),
        .mem_addr          (mem_addr),
        .mem_re            (mem_re),
        .mem_dout          (mem_dout),
        .wr_req            (wr_req),
        .wr_gnt            (wr_gnt),
        .grp_idx           (grp_idx),
        .all_fed           (all_fed)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: word k holds the value k.
    always @(posedge clk) begin
        if (mem_re) mem_dout <= DW'(mem_addr);
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_re) addr_log.push_back(int'(mem_addr));
        check("re_gnt_overlap", DW'(mem_re & wr_gnt), '0);
        if (descriptor_valid) begin
            n_valid++;
            if (sb.size() > 0) begin
                mon_base = sb.pop_front();
                check("slot0", image_R_C_D_0, DW'(mon_base));
                check("slot1", image_R_C_D_1, DW'(mon_base + 1));
                check("slot2", image_R_C_D_2, DW'(mon_base + 2));
                check("slot3", image_R_C_D_3, DW'(mon_base + 3));
            end else begin
                check("unexpected_valid", DW'(descriptor_valid), '0);
            end
        end
    end

    task automatic do_start(input int k);
        @(posedge clk); #1;
        kpt_num = 11'(k);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Request group g; optionally raise wr_req after posedge number wr_at of the fetch.
    task automatic req_group(input int g, input int wr_at, input string tag);
        int lat = 0;
        sb.push_back(4 * g);
        addr_log.delete();
        @(posedge clk); #1;
        descriptor_request = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == wr_at) wr_req = 1'b1;
            @(negedge clk);
            if (wr_req) check({tag, "_wr_blocked"}, DW'(wr_gnt), '0);
            if (descriptor_valid) begin
                lat = n;
                break;
            end
        end
        descriptor_request = 1'b0;
        check({tag, "_latency"}, DW'(lat), DW'(6));
        check({tag, "_nreads"}, DW'(addr_log.size()), DW'(4));
        for (int i = 0; i < addr_log.size() && i < 4; i++) begin
            check({tag, "_addr"}, DW'(addr_log[i]), DW'(4 * g + i));
        end
        if (wr_at > 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_wr_regrant"}, DW'(wr_gnt), DW'(1));
            wr_req = 1'b0;
        end
    endtask

    task automatic idle_req(input int cycles, input string tag);
        int v0 = n_valid;
        addr_log.delete();
        @(posedge clk); #1;
        descriptor_request = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        descriptor_request = 1'b0;
        @(negedge clk);
        check({tag, "_reads"}, DW'(addr_log.size()), '0);
        check({tag, "_valids"}, DW'(n_valid - v0), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        rst_n = 1'b0;
        start = 1'b0;
        kpt_num = '0;
        descriptor_request = 1'b0;
        wr_req = 1'b1;
        #2;
        check("rst_valid", DW'(descriptor_valid), '0);
        check("rst_re", DW'(mem_re), '0);
        check("rst_addr", DW'(mem_addr), '0);
        check("rst_grp_idx", DW'(grp_idx), '0);
        check("rst_all_fed", DW'(all_fed), '0);
        check("rst_slot0", image_R_C_D_0, '0);
        check("rst_wr_gnt_idle", DW'(wr_gnt), DW'(1));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_req = 1'b0;

        // Two full groups, then requests are ignored.
        do_start(8);
        @(negedge clk);
        check("t1_all_fed_start", DW'(all_fed), '0);
        req_group(0, -1, "t1g0");
        @(negedge clk);
        check("t1_grp_idx1", DW'(grp_idx), DW'(1));
        check("t1_not_fed", DW'(all_fed), '0);
        req_group(1, -1, "t1g1");
        @(negedge clk);
        check("t1_grp_idx2", DW'(grp_idx), DW'(2));
        check("t1_all_fed", DW'(all_fed), DW'(1));
        idle_req(10, "t1_extra");

        // Partial trailing group is never fetched.
        do_start(10);
        v0 = n_valid;
        req_group(0, -1, "t2g0");
        req_group(1, -1, "t2g1");
        @(negedge clk);
        check("t2_all_fed", DW'(all_fed), DW'(1));
        idle_req(10, "t2_extra");
        check("t2_pulses", DW'(n_valid - v0), DW'(2));

        // Fewer than four keypoints: nothing to feed.
        do_start(3);
        @(negedge clk);
        check("t3_all_fed", DW'(all_fed), DW'(1));
        idle_req(20, "t3_req");

        // Writer and request together: writer wins until it lets go.
        do_start(8);
        sb.push_back(0);
        @(posedge clk); #1;
        wr_req = 1'b1;
        descriptor_request = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_gnt", DW'(wr_gnt), DW'(1));
            check("t4_no_re", DW'(mem_re), '0);
        end
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_re_next", DW'(mem_re), DW'(1));
        check("t4_addr0", DW'(mem_addr), '0);
        v0 = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (descriptor_valid) begin
                v0 = 1;
                break;
            end
        end
        descriptor_request = 1'b0;
        check("t4_valid_seen", DW'(v0), DW'(1));

        // Writer arrives mid-fetch and waits until the fetch completes.
        req_group(1, 2, "t5");

        // Abort by start at fetch count 2.
        do_start(8);
        v0 = n_valid;
        @(posedge clk); #1;
        descriptor_request = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        descriptor_request = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t6_re_off", DW'(mem_re), '0);
        check("t6_grp_idx", DW'(grp_idx), '0);
        repeat (10) @(posedge clk);
        check("t6_no_valid", DW'(n_valid - v0), '0);
        req_group(0, -1, "t6g0");

        // Asynchronous reset at fetch count 2.
        do_start(8);
        v0 = n_valid;
        @(posedge clk); #1;
        descriptor_request = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t7_pre_addr", DW'(mem_addr), DW'(2));
        rst_n = 1'b0;
        wr_req = 1'b1;
        #1;
        check("t7_valid", DW'(descriptor_valid), '0);
        check("t7_re", DW'(mem_re), '0);
        check("t7_addr", DW'(mem_addr), '0);
        check("t7_grp_idx", DW'(grp_idx), '0);
        check("t7_all_fed", DW'(all_fed), '0);
        check("t7_slot1", image_R_C_D_1, '0);
        check("t7_slot3", image_R_C_D_3, '0);
        check("t7_wr_gnt_idle", DW'(wr_gnt), DW'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        descriptor_request = 1'b0;
        @(negedge clk);
        check("t7_no_valid", DW'(n_valid - v0), '0);
        check("t7_idle_not_fed", DW'(all_fed), '0);

        check("sb_drained", DW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
